global_lock_arbiter: RTL and testbench
======================================

Name: global_lock_arbiter

Overview:
- N-core successor to the two-core global-memory/lock hookup used by the lockstep cores.
- Owns the shared global data RAM and arbitrates one mutual-exclusion lock among NUM_CORES requesters using round-robin.
- Returns a stall ("lock") to requesting cores that have not been granted, and gates global writes from cores that do not own the lock.
- Sits between the core array and global memory; each core's need_lock/gaddress/gdata/gwren come in, and lock/gq go back out.

Parameters:
- NUM_CORES, 2: number of core ports; range 2..8.
- ADDR_W, 6: global word address width; RAM depth is 2**ADDR_W.
- DATA_W, 32: data word width.
- HOLD_MAX, 255: maximum cycles a lock may be held. Used only with LOCK_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- need_lock  in  NUM_CORES  per-core lock request; level, held high while in the critical section.
- gaddress  in  NUM_CORES*ADDR_W  per-core word address; core i occupies bits [i*ADDR_W +: ADDR_W].
- gdata  in  NUM_CORES*DATA_W  per-core write data.
- gwren  in  NUM_CORES  per-core write enable.
- lock  out  NUM_CORES  per-core stall; 1 = core must hold its current state.
- gq  out  NUM_CORES*DATA_W  per-core read data.
- owner  out  3  index of the current lock holder.
- owner_valid  out  1  lock currently held.
- wr_blocked  out  1  one-cycle pulse: at least one write was dropped this cycle.
- timeout  out  1  one-cycle pulse on forced revoke. Tied 0 without LOCK_TIMEOUT_EN.

Behaviour:
- Reset (rst low, async):
  - lock=0, gq=0, owner=0, owner_valid=0, wr_blocked=0, timeout=0.
  - Round-robin pointer rr=0, state=IDLE, hold counter=0, revoke mask=0.
  - RAM contents are retained (not cleared).
- FSM states: IDLE, HELD, REL.
  - IDLE: if any eligible need_lock[i] is high (eligible = not masked), grant the first requester searching from rr upward with wrap-around. Set owner=i, owner_valid=1, rr=(i+1) mod NUM_CORES, go to HELD. Otherwise stay in IDLE.
  - HELD: if need_lock[owner]==0, clear owner_valid and go to REL. Otherwise stay in HELD.
  - REL: exactly one cycle with no owner, then go to IDLE. No grant is issued in REL, so release-to-regrant is at least 2 cycles.
- Grant latency: need_lock sampled high at edge k in IDLE gives owner/owner_valid valid after edge k.
- lock[i] is registered and computed from the next state:
  - lock[i] = need_lock[i] AND NOT(next owner_valid AND next owner==i).
  - The granted core therefore sees lock=0 on the same edge its grant appears; losers see lock=1 from that edge.
  - Cores not requesting always see lock=0.
- Simultaneous requests in IDLE: round-robin order decides. A grant and a release can never occur in the same cycle.
- RAM read: gq[i] <= mem[gaddress[i]] on every edge, for every port (1-cycle latency).
  - Read-during-write to the same address returns the old data.
- RAM write, evaluated each edge:
  - Eligible writers: the owner only when owner_valid=1; otherwise all cores.
  - Of the eligible cores with gwren=1, the lowest index writes gdata to its gaddress.
  - Every other asserted gwren is dropped, and wr_blocked pulses for that cycle.
- Owner or address width: owner index is zero-extended into 3 bits. gaddress is used unmodified, with no wrap logic needed.
- A request dropped before it is granted leaves state unchanged.
- Reset asserted mid-hold: lock is released immediately and asynchronously; all outputs return to reset values.

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- With the macro defined:
  - The hold counter increments every HELD cycle and clears when leaving HELD.
  - When it reaches HELD_MAX (=HOLD_MAX): force a revoke, pulse timeout for 1 cycle, set mask[owner]=1, and go to REL.
  - A masked core is ineligible for grant, and lock[i]=1 while need_lock[i] is high.
  - mask[i] clears when need_lock[i] goes low.
- Without the macro: no counter or mask logic; timeout is tied to 0; a lock is held indefinitely.

Test Plan:
- need_lock=01 at edge 5 → owner=0, owner_valid=1, lock=00 after edge 5. Core 0 writes 0xDEADBEEF to address 3; core 1 reads address 3 → gq[1]=0xDEADBEEF one cycle after the write.
- need_lock=11 in IDLE with rr=0 → owner=0, lock=10. Drop need_lock[0] → REL for 1 cycle, then owner=1, lock=00. Next contention with rr=0 grants core 0.
- Core 0 holds the lock; core 1 asserts gwren with address 5, data 0x1234 → RAM[5] unchanged, wr_blocked=1 for 1 cycle.
- No owner; cores 0 and 1 both write address 7 (0xAAAA and 0x5555) in the same cycle → RAM[7]=0xAAAA, wr_blocked pulses.
- LOCK_TIMEOUT_EN with HOLD_MAX=4: core 0 holds for 4 cycles → timeout pulse, owner_valid=0. Core 0 keeps need_lock high → lock[0]=1 and is never granted until need_lock[0] goes low.
- Drive rst low while core 1 owns the lock → owner_valid=0, lock=00, gq=0 immediately (asynchronously). After reset release, a request is granted normally.

Source files
------------

// File: rtl/global_lock_arbiter.sv
// Shared global RAM plus a round-robin mutual-exclusion lock for NUM_CORES cores.
// Optional forced-revoke hold timer is enabled by defining LOCK_TIMEOUT_EN.
module global_lock_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int HOLD_MAX  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CORES-1:0]         need_lock,
    input  logic [NUM_CORES*ADDR_W-1:0]  gaddress,
    input  logic [NUM_CORES*DATA_W-1:0]  gdata,
    input  logic [NUM_CORES-1:0]         gwren,
    output logic [NUM_CORES-1:0]         lock,
    output logic [NUM_CORES*DATA_W-1:0]  gq,
    output logic [2:0]                   owner,
    output logic                         owner_valid,
    output logic                         wr_blocked,
    output logic                         timeout
);

    if (NUM_CORES < 2 || NUM_CORES > 8 || HOLD_MAX < 1) begin : g_param_check
        $error("global_lock_arbiter: NUM_CORES must be 2..8 and HOLD_MAX >= 1");
    end

    typedef enum logic [1:0] {IDLE, HELD, REL} state_t;

    state_t                 state, state_n;
    logic [2:0]             rr, rr_n, owner_n, grant_idx;
    logic                   owner_valid_n, found, own_req;
    logic [NUM_CORES-1:0]   eligible, owner_oh, lock_n;
    logic                   wr_en, blocked;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [DATA_W-1:0]      mem [2**ADDR_W];

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            owner_oh[i] = owner_valid && (owner == 3'(i));
        end
    end

    assign own_req = |(need_lock & owner_oh);

`ifdef LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0]     hold_cnt, hold_cnt_n;
    logic [NUM_CORES-1:0] mask, mask_n;
    logic                 revoke;

    assign eligible = need_lock & ~mask;
`else
    assign eligible = need_lock;
    assign timeout  = 1'b0;
`endif

    // Round-robin pick: first eligible index at or above rr, else wrap to the lowest.
    always_comb begin
        found     = 1'b0;
        grant_idx = rr;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && eligible[i] && (3'(i) >= rr)) begin
                found     = 1'b1;
                grant_idx = 3'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && eligible[i]) begin
                found     = 1'b1;
                grant_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_n       = state;
        owner_n       = owner;
        owner_valid_n = owner_valid;
        rr_n          = rr;
`ifdef LOCK_TIMEOUT_EN
        revoke        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n       = grant_idx;
                    owner_valid_n = 1'b1;
                    rr_n          = (grant_idx == 3'(NUM_CORES - 1)) ? 3'd0 : grant_idx + 3'd1;
                    state_n       = HELD;
                end
            end
            HELD: begin
                if (!own_req) begin
                    owner_valid_n = 1'b0;
                    state_n       = REL;
                end
`ifdef LOCK_TIMEOUT_EN
                else if (hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
                    revoke        = 1'b1;
                    owner_valid_n = 1'b0;
                    state_n       = REL;
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        // Stall is derived from the post-edge owner so a winner never sees a stale stall.
        for (int i = 0; i < NUM_CORES; i++) begin
            lock_n[i] = need_lock[i] & ~(owner_valid_n && (owner_n == 3'(i)));
        end
    end

`ifdef LOCK_TIMEOUT_EN
    always_comb begin
        hold_cnt_n = '0;
        if (state == HELD && state_n == HELD) begin
            hold_cnt_n = hold_cnt + 1'b1;
        end
        mask_n = mask & need_lock;
        if (revoke) begin
            mask_n = mask_n | owner_oh;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            mask     <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_n;
            mask     <= mask_n;
            timeout  <= revoke;
        end
    end
`endif

    // Write arbitration: lowest-index eligible writer wins, every other gwren is dropped.
    always_comb begin
        wr_en   = 1'b0;
        blocked = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gwren[i]) begin
                if (!wr_en && (!owner_valid || owner_oh[i])) begin
                    wr_en   = 1'b1;
                    wr_addr = gaddress[i*ADDR_W +: ADDR_W];
                    wr_data = gdata[i*DATA_W +: DATA_W];
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr          <= 3'd0;
            owner       <= 3'd0;
            owner_valid <= 1'b0;
            lock        <= '0;
            wr_blocked  <= 1'b0;
            gq          <= '0;
        end else begin
            state       <= state_n;
            rr          <= rr_n;
            owner       <= owner_n;
            owner_valid <= owner_valid_n;
            lock        <= lock_n;
            wr_blocked  <= blocked;
            for (int i = 0; i < NUM_CORES; i++) begin
                gq[i*DATA_W +: DATA_W] <= mem[gaddress[i*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule

// File: tb/tb_global_lock_arbiter.sv
// Directed bench for global_lock_arbiter: grant order, write gating, RAM access and async reset.
// Also exercises the forced-revoke path when compiled with LOCK_TIMEOUT_EN.
module tb_global_lock_arbiter;

    localparam int NC = 2;
    localparam int AW = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     need_lock;
    logic [NC*AW-1:0]  gaddress;
    logic [NC*DW-1:0]  gdata;
    logic [NC-1:0]     gwren;
    logic [NC-1:0]     lock;
    logic [NC*DW-1:0]  gq;
    logic [2:0]        owner;
    logic              owner_valid;
    logic              wr_blocked;
    logic              timeout;

    int total  = 0;
    int passed = 0;

    global_lock_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .HOLD_MAX  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .need_lock   (need_lock),
        .gaddress    (gaddress),
        .gdata       (gdata),
        .gwren       (gwren),
        .lock        (lock),
        .gq          (gq),
        .owner       (owner),
        .owner_valid (owner_valid),
        .wr_blocked  (wr_blocked),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_arb(input string tag, input logic ov, input logic [2:0] own,
                             input logic [NC-1:0] lk);
        check({tag, ".owner_valid"}, 64'(owner_valid), 64'(ov));
        if (ov) check({tag, ".owner"}, 64'(owner), 64'(own));
        check({tag, ".lock"}, 64'(lock), 64'(lk));
    endtask

    initial begin
        rst       = 1'b0;
        need_lock = '0;
        gaddress  = '0;
        gdata     = '0;
        gwren     = '0;
        step();
        step();
        check("rst.lock", 64'(lock), 64'd0);
        check("rst.gq", 64'(gq), 64'd0);
        check("rst.owner", 64'(owner), 64'd0);
        check("rst.owner_valid", 64'(owner_valid), 64'd0);
        check("rst.wr_blocked", 64'(wr_blocked), 64'd0);
        check("rst.timeout", 64'(timeout), 64'd0);
        rst = 1'b1;
        step();

        // Seed RAM[5] while no one owns the lock.
        gaddress[AW +: AW] = 6'd5;
        gdata[DW +: DW]    = 32'h0000_5A5A;
        gwren              = 2'b10;
        step();
        check("seed.wr_blocked", 64'(wr_blocked), 64'd0);
        gwren = 2'b00;

        // Single requester, owner writes, other core reads the new word.
        need_lock = 2'b01;
        step();
        check_arb("grant0", 1'b1, 3'd0, 2'b00);
        gaddress[0 +: AW]  = 6'd3;
        gdata[0 +: DW]     = 32'hDEAD_BEEF;
        gaddress[AW +: AW] = 6'd3;
        gwren              = 2'b01;
        step();
        check("ownwr.wr_blocked", 64'(wr_blocked), 64'd0);
        gwren = 2'b00;
        step();
        check("rd3.gq1", 64'(gq[DW +: DW]), 64'hDEAD_BEEF);
        need_lock = 2'b00;
        step();
        check_arb("rel0", 1'b0, 3'd0, 2'b00);
        step();

        // Core 1 takes and drops the lock so rr returns to 0.
        need_lock = 2'b10;
        step();
        check_arb("grant1", 1'b1, 3'd1, 2'b00);
        need_lock = 2'b00;
        step();
        step();

        // Contention with rr=0: core 0 wins, core 1 stalls.
        need_lock = 2'b11;
        step();
        check_arb("cont.a", 1'b1, 3'd0, 2'b10);

        // Non-owner write is dropped.
        gaddress[AW +: AW] = 6'd5;
        gdata[DW +: DW]    = 32'h0000_1234;
        gwren              = 2'b10;
        step();
        check("blk.wr_blocked", 64'(wr_blocked), 64'd1);
        gwren             = 2'b00;
        gaddress[0 +: AW] = 6'd5;
        step();
        check("blk.pulse_end", 64'(wr_blocked), 64'd0);
        check("blk.ram5", 64'(gq[0 +: DW]), 64'h0000_5A5A);
        check_arb("cont.hold", 1'b1, 3'd0, 2'b10);

        // Release: exactly one REL cycle, then core 1 is granted.
        need_lock = 2'b10;
        step();
        check_arb("rel.a", 1'b0, 3'd0, 2'b10);
        step();
        check_arb("idle.a", 1'b0, 3'd0, 2'b10);
        step();
        check_arb("cont.b", 1'b1, 3'd1, 2'b00);
        need_lock = 2'b00;
        step();
        step();
        need_lock = 2'b11;
        step();
        check_arb("cont.c", 1'b1, 3'd0, 2'b10);
        need_lock = 2'b00;
        step();
        step();

        // Unowned simultaneous writes: lowest index wins.
        gaddress[0 +: AW]  = 6'd7;
        gaddress[AW +: AW] = 6'd7;
        gdata[0 +: DW]     = 32'h0000_AAAA;
        gdata[DW +: DW]    = 32'h0000_5555;
        gwren              = 2'b11;
        step();
        check("dual.wr_blocked", 64'(wr_blocked), 64'd1);
        gwren = 2'b00;
        step();
        check("dual.gq0", 64'(gq[0 +: DW]), 64'h0000_AAAA);
        check("dual.gq1", 64'(gq[DW +: DW]), 64'h0000_AAAA);
        check("dual.pulse_end", 64'(wr_blocked), 64'd0);

        // Async reset while core 1 holds the lock.
        need_lock = 2'b10;
        step();
        check_arb("pre_rst", 1'b1, 3'd1, 2'b00);
        need_lock = 2'b11;
        step();
        check_arb("pre_rst.b", 1'b1, 3'd1, 2'b01);
        #2;
        rst = 1'b0;
        #1;
        check("arst.owner_valid", 64'(owner_valid), 64'd0);
        check("arst.owner", 64'(owner), 64'd0);
        check("arst.lock", 64'(lock), 64'd0);
        check("arst.gq", 64'(gq), 64'd0);
        rst = 1'b1;
        step();
        check_arb("post_rst", 1'b1, 3'd0, 2'b10);

`ifdef LOCK_TIMEOUT_EN
        // Core 0 keeps requesting past the hold limit and gets revoked and masked.
        step();
        step();
        step();
        check_arb("to.hold", 1'b1, 3'd0, 2'b10);
        check("to.no_pulse", 64'(timeout), 64'd0);
        step();
        check_arb("to.revoke", 1'b0, 3'd0, 2'b11);
        check("to.pulse", 64'(timeout), 64'd1);
        step();
        check("to.pulse_end", 64'(timeout), 64'd0);
        step();
        check_arb("to.other", 1'b1, 3'd1, 2'b01);
        need_lock = 2'b01;
        step();
        step();
        step();
        check_arb("to.masked", 1'b0, 3'd0, 2'b01);
        need_lock = 2'b00;
        step();
        check("to.unmask", 64'(lock), 64'd0);
        need_lock = 2'b01;
        step();
        check_arb("to.regrant", 1'b1, 3'd0, 2'b00);
`else
        check("timeout.tied", 64'(timeout), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
